// File: rtl/axi_node_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_node_pkg : shared ID word type and width helper for the AXI node
// Rev 1.0
// ---------------------------------------------------------------------------
package axi_node_pkg;

  localparam int DEF_N_TARG_PORT = 7;
  localparam int DEF_LOG_N_TARG  = $clog2(DEF_N_TARG_PORT);

  // {BIN_ID, OH_ID} for the default port count
  typedef struct packed {
    logic [DEF_LOG_N_TARG-1:0]  bin_id;
    logic [DEF_N_TARG_PORT-1:0] oh_id;
  } id_word_t;

  function automatic int id_width(input int log_n_targ, input int n_targ);
    return log_n_targ + n_targ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_node_id_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_node_id_fifo : ID queue of granted AW bursts, no fall-through
// Rev 1.0
// ---------------------------------------------------------------------------
module axi_node_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign data_out = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule
`default_nettype wire

// File: rtl/axi_w_data_router.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_w_data_router : forwards W beats of the port at the ID FIFO head
// Rev 1.0
// ---------------------------------------------------------------------------
module axi_w_data_router
  import axi_node_pkg::*;
#(
  parameter int AXI_DATA_W  = 64,
  parameter int AXI_USER_W  = 6,
  parameter int N_TARG_PORT = 7,
  parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [N_TARG_PORT-1:0][AXI_DATA_W-1:0]  wdata_i,
  input  logic [N_TARG_PORT-1:0][AXI_DATA_W/8-1:0] wstrb_i,
  input  logic [N_TARG_PORT-1:0]                  wlast_i,
  input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]  wuser_i,
  input  logic [N_TARG_PORT-1:0]                  wvalid_i,
  output logic [N_TARG_PORT-1:0]                  wready_o,
  output logic [AXI_DATA_W-1:0]                   wdata_o,
  output logic [AXI_DATA_W/8-1:0]                 wstrb_o,
  output logic                                    wlast_o,
  output logic [AXI_USER_W-1:0]                   wuser_o,
  output logic                                    wvalid_o,
  input  logic                                    wready_i,
  input  logic                                    push_ID_i,
  input  logic [LOG_N_TARG+N_TARG_PORT-1:0]       ID_i,
  output logic                                    grant_FIFO_ID_o
);

  localparam int ID_W = id_width(LOG_N_TARG, N_TARG_PORT);

  logic [ID_W-1:0]         head_id;
  logic [N_TARG_PORT-1:0]  h_oh;
  logic [LOG_N_TARG-1:0]   h_bin;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop;

  logic [AXI_DATA_W-1:0]   sel_data;
  logic [AXI_DATA_W/8-1:0] sel_strb;
  logic                    sel_last;
  logic [AXI_USER_W-1:0]   sel_user;

  axi_node_id_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_ID_i),
    .pop      (pop),
    .data_in  (ID_i),
    .data_out (head_id),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign h_oh            = head_id[N_TARG_PORT-1:0];
  assign h_bin           = head_id[ID_W-1 -: LOG_N_TARG];
  assign grant_FIFO_ID_o = ~fifo_full;

  // Compare-based mux keeps unused binary codes from indexing past the array
  always_comb begin
    sel_data = '0;
    sel_strb = '0;
    sel_last = 1'b0;
    sel_user = '0;
    for (int i = 0; i < N_TARG_PORT; i++) begin
      if (h_bin == LOG_N_TARG'(i)) begin
        sel_data = wdata_i[i];
        sel_strb = wstrb_i[i];
        sel_last = wlast_i[i];
        sel_user = wuser_i[i];
      end
    end
  end

  assign wvalid_o = ~fifo_empty & |(wvalid_i & h_oh);
  assign wready_o = (fifo_empty ? '0 : h_oh) & {N_TARG_PORT{wready_i}};
  assign wdata_o  = fifo_empty ? '0 : sel_data;
  assign wstrb_o  = fifo_empty ? '0 : sel_strb;
  assign wlast_o  = ~fifo_empty & sel_last;
  assign wuser_o  = fifo_empty ? '0 : sel_user;

  assign pop = wvalid_o & wready_i & wlast_o;

endmodule
`default_nettype wire

// File: tb/tb_axi_w_data_router.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi_w_data_router : table, directed and random checks against a queue model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_axi_w_data_router;
  import axi_node_pkg::*;

  localparam int N   = 7;
  localparam int DW  = 64;
  localparam int UW  = 6;
  localparam int LG  = 3;
  localparam int SW  = DW / 8;
  localparam int IDW = LG + N;
  localparam int DEP = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N-1:0][DW-1:0]     wdata_i;
  logic [N-1:0][SW-1:0]     wstrb_i;
  logic [N-1:0]             wlast_i;
  logic [N-1:0][UW-1:0]     wuser_i;
  logic [N-1:0]             wvalid_i;
  logic [N-1:0]             wready_o;
  logic [DW-1:0]            wdata_o;
  logic [SW-1:0]            wstrb_o;
  logic                     wlast_o;
  logic [UW-1:0]            wuser_o;
  logic                     wvalid_o;
  logic                     wready_i;
  logic                     push_ID_i;
  logic [IDW-1:0]           ID_i;
  logic                     grant_FIFO_ID_o;

  axi_w_data_router #(
    .AXI_DATA_W  (DW),
    .AXI_USER_W  (UW),
    .N_TARG_PORT (N),
    .LOG_N_TARG  (LG),
    .FIFO_DEPTH  (DEP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wdata_i         (wdata_i),
    .wstrb_i         (wstrb_i),
    .wlast_i         (wlast_i),
    .wuser_i         (wuser_i),
    .wvalid_i        (wvalid_i),
    .wready_o        (wready_o),
    .wdata_o         (wdata_o),
    .wstrb_o         (wstrb_o),
    .wlast_o         (wlast_o),
    .wuser_o         (wuser_o),
    .wvalid_o        (wvalid_o),
    .wready_i        (wready_i),
    .push_ID_i       (push_ID_i),
    .ID_i            (ID_i),
    .grant_FIFO_ID_o (grant_FIFO_ID_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int q[$];          // ports of queued bursts, head first
  bit known = 1'b0;

  typedef struct {
    bit         rst;
    bit         push;
    int         port;
    bit [N-1:0] wv;
    bit [N-1:0] wl;
    bit         wr;
    bit         e_grant;
    bit         e_wvalid;
    bit [N-1:0] e_wready;
  } vec_t;

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      wdata_i[i] = {$urandom, $urandom};
      wstrb_i[i] = SW'($urandom);
      wuser_i[i] = UW'($urandom);
    end
  endtask

  task automatic set_push(input bit en, input int p);
    id_word_t w;
    logic [N-1:0] one;
    one      = 1;
    w.bin_id = LG'(p);
    w.oh_id  = one << p;
    push_ID_i = en;
    ID_i      = en ? w : '0;
  endtask

  // Compare every output against the queue model, then advance model and clock
  task automatic finish_cycle(input string tag);
    logic [87:0]  e;
    logic [87:0]  a;
    logic [N-1:0] one;
    int           sz;
    int           p;
    bit           pop;
    bit           psh;
    one = 1;
    sz  = q.size();
    pop = 1'b0;
    if (known) begin
      e = '0;
      e[87] = (sz < DEP);
      if (sz > 0) begin
        p = q[0];
        e[86]    = wvalid_i[p];
        e[85:79] = wready_i ? (one << p) : '0;
        e[78]    = wlast_i[p];
        e[77:72] = wuser_i[p];
        e[71:64] = wstrb_i[p];
        e[63:0]  = wdata_i[p];
      end
      a = {grant_FIFO_ID_o, wvalid_o, wready_o, wlast_o, wuser_o, wstrb_o, wdata_o};
      cmp(tag, a, e);
    end
    if (sz > 0) pop = wvalid_i[q[0]] && wready_i && wlast_i[q[0]];
    psh = push_ID_i && (sz < DEP);
    if (!rst_n) begin
      q.delete();
      known = 1'b1;
    end else if (known) begin
      if (pop) void'(q.pop_front());
      if (psh) q.push_back(int'(ID_i[IDW-1 -: LG]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst_n    = 1'b1;
    set_push(1'b0, 0);
    wvalid_i = '0;
    wlast_i  = '0;
    wready_i = 1'b1;
    rand_data();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #4;
    finish_cycle("reset");
    rst_n = 1'b1;
  endtask

  vec_t tbl[13];
  int   got[$];
  logic [DW-1:0] held;
  logic [N-1:0]  one;

  initial begin
    one = 1;
    // push/port   wv     wl     wr | grant wvalid wready
    tbl[0]  = '{0, 1, 2, 7'h7F, 7'h00, 1, 1, 0, 7'h00};
    tbl[1]  = '{0, 0, 0, 7'h04, 7'h00, 1, 1, 1, 7'h04};
    tbl[2]  = '{0, 0, 0, 7'h04, 7'h00, 1, 1, 1, 7'h04};
    tbl[3]  = '{0, 0, 0, 7'h04, 7'h00, 1, 1, 1, 7'h04};
    tbl[4]  = '{0, 0, 0, 7'h04, 7'h04, 1, 1, 1, 7'h04};
    tbl[5]  = '{0, 0, 0, 7'h04, 7'h04, 1, 1, 0, 7'h00};
    tbl[6]  = '{0, 1, 1, 7'h00, 7'h00, 1, 1, 0, 7'h00};
    tbl[7]  = '{0, 1, 3, 7'h00, 7'h00, 1, 1, 0, 7'h02};
    tbl[8]  = '{0, 1, 5, 7'h00, 7'h00, 1, 1, 0, 7'h02};
    tbl[9]  = '{0, 1, 6, 7'h00, 7'h00, 1, 1, 0, 7'h02};
    tbl[10] = '{0, 0, 0, 7'h00, 7'h00, 1, 0, 0, 7'h02};
    tbl[11] = '{0, 0, 0, 7'h02, 7'h02, 1, 0, 1, 7'h02};
    tbl[12] = '{0, 0, 0, 7'h7F, 7'h00, 0, 1, 1, 7'h00};

    idle_inputs();
    rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    do_reset();

    // T1: empty after reset with every port requesting
    wvalid_i = '1;
    #4;
    cmp("t1_grant", grant_FIFO_ID_o, 1);
    cmp("t1_wvalid", wvalid_o, 0);
    cmp("t1_wready", wready_o, 0);
    finish_cycle("t1");

    // T2 and T4 as a vector table
    for (int k = 0; k < 13; k++) begin
      rst_n = ~tbl[k].rst;
      set_push(tbl[k].push, tbl[k].port);
      wvalid_i = tbl[k].wv;
      wlast_i  = tbl[k].wl;
      wready_i = tbl[k].wr;
      rand_data();
      #4;
      cmp($sformatf("tbl%0d_grant", k), grant_FIFO_ID_o, tbl[k].e_grant);
      cmp($sformatf("tbl%0d_wvalid", k), wvalid_o, tbl[k].e_wvalid);
      cmp($sformatf("tbl%0d_wready", k), wready_o, tbl[k].e_wready);
      finish_cycle($sformatf("tbl%0d_model", k));
    end

    // T3: bursts leave in grant order 5, 1, 3
    do_reset();
    for (int c = 0; c < 12; c++) begin
      rand_data();
      for (int i = 0; i < N; i++) wuser_i[i] = UW'(i);
      wvalid_i = '1;
      wlast_i  = (c % 3 == 2) ? '1 : '0;
      wready_i = 1'b1;
      case (c)
        0:       set_push(1'b1, 5);
        1:       set_push(1'b1, 1);
        2:       set_push(1'b1, 3);
        default: set_push(1'b0, 0);
      endcase
      #4;
      if (c == 1 || c == 2) cmp($sformatf("t3_stall%0d", c), wready_o & 7'h0A, 0);
      if (wvalid_o && wlast_o && wready_i) got.push_back(int'(wuser_o));
      finish_cycle($sformatf("t3_c%0d", c));
    end
    cmp("t3_count", got.size(), 3);
    if (got.size() == 3) begin
      cmp("t3_first", got[0], 5);
      cmp("t3_second", got[1], 1);
      cmp("t3_third", got[2], 3);
    end

    // T5: hold two entries while pushing and popping each cycle
    do_reset();
    set_push(1'b1, 0);
    #4;
    finish_cycle("t5_fill0");
    set_push(1'b1, 1);
    #4;
    finish_cycle("t5_fill1");
    for (int k = 0; k < 10; k++) begin
      rand_data();
      set_push(1'b1, (k + 2) % N);
      wvalid_i = '1;
      wlast_i  = '1;
      wready_i = 1'b1;
      #4;
      cmp($sformatf("t5_grant%0d", k), grant_FIFO_ID_o, 1);
      cmp($sformatf("t5_head%0d", k), wready_o, one << (k % N));
      finish_cycle($sformatf("t5_i%0d", k));
    end

    // T6: stall mid-burst, then reset mid-burst
    do_reset();
    set_push(1'b1, 4);
    #4;
    finish_cycle("t6_push");
    set_push(1'b0, 0);
    wvalid_i = 7'h10;
    #4;
    finish_cycle("t6_beat1");
    held     = wdata_i[4];
    wready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #4;
      cmp($sformatf("t6_wready%0d", k), wready_o, 0);
      cmp($sformatf("t6_hold%0d", k), wdata_o, held);
      finish_cycle($sformatf("t6_stall%0d", k));
    end
    rst_n = 1'b0;
    #4;
    finish_cycle("t6_rst");
    rst_n    = 1'b1;
    wvalid_i = '1;
    wready_i = 1'b1;
    wlast_i  = '1;
    #4;
    cmp("t6_wvalid", wvalid_o, 0);
    cmp("t6_grant", grant_FIFO_ID_o, 1);
    cmp("t6_wready", wready_o, 0);
    finish_cycle("t6_after");

    // Random traffic against the queue model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      set_push(($urandom_range(0, 1) == 1) && (q.size() < DEP), $urandom_range(0, N - 1));
      rand_data();
      wvalid_i = N'($urandom);
      for (int i = 0; i < N; i++) wlast_i[i] = ($urandom_range(0, 3) == 0);
      wready_i = ($urandom_range(0, 3) != 0);
      #4;
      finish_cycle($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
